automaton: RTL and testbench

One-dimensional elementary cellular automaton (Wolfram rule set) of WIDTH cells on a ring. The cell row is held in a register and advances one generation every 2·N clock cycles through an internal prescaler. It sits downstream of the board clock and drives a display or logger with the current generation. The rule and seed pattern are compile-time parameters.

---
 rtl/automaton_pkg.sv | 26 ++
 rtl/automaton_prescaler.sv | 28 ++
 rtl/automaton.sv | 57 +++++
 tb/tb_automaton.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/automaton_pkg.sv
// Shared helpers for the elementary cellular automaton: ring-neighbour indexing
// and Wolfram rule lookup.
package automaton_pkg;

  localparam int NBR_BITS = 3;

  typedef logic [NBR_BITS-1:0] nbr_t;

  // {left, self, right}, with left as the MSB.
  function automatic nbr_t nbr_idx(input logic left, input logic mid, input logic right);
    return {left, mid, right};
  endfunction

  function automatic logic rule_bit(input logic [7:0] rule, input nbr_t k);
    return rule[k];
  endfunction

  function automatic int ring_left(input int i, input int width);
    return (i + 1) % width;
  endfunction

  function automatic int ring_right(input int i, input int width);
    return (i + width - 1) % width;
  endfunction

endpackage

// File: rtl/automaton_prescaler.sv
// Prescaler for the automaton: counts 0..2N-1 and strobes en on the last count.
module ca_prescaler #(
  parameter int N = 1
) (
  input  logic clk,
  input  logic rst,
  output logic en
);

  localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam logic [CW-1:0] TOP = CW'(2 * N - 1);

  // Power-up value matches reset so the block runs with rst tied low.
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (rst || cnt_q == TOP) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign en = (cnt_q == TOP);

endmodule

// File: rtl/automaton.sv
// Elementary cellular automaton on a ring of WIDTH cells, advancing one
// generation per prescaler period; tick marks the cycle after each advance.
module automaton
  import automaton_pkg::*;
#(
  parameter int             WIDTH = 80,
  parameter logic [7:0]     RULE  = 8'd30,
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1} << (WIDTH / 2),
  parameter int             N     = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] data,
  output logic             tick
);

  logic             en;
  logic [WIDTH-1:0] next_row;
  logic [WIDTH-1:0] data_d;
  logic             tick_d;
  logic [WIDTH-1:0] data_q = SEED;
  logic             tick_q = 1'b0;

  ca_prescaler #(.N(N)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en)
  );

  // Every cell looks only at the registered row, so all cells update together.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    localparam int L = ring_left(gi, WIDTH);
    localparam int R = ring_right(gi, WIDTH);
    assign next_row[gi] = rule_bit(RULE, nbr_idx(data_q[L], data_q[gi], data_q[R]));
  end

  // Reset wins over an advance that lands in the same cycle.
  always_comb begin
    data_d = data_q;
    tick_d = 1'b0;
    if (rst) begin
      data_d = SEED;
    end else if (en) begin
      data_d = next_row;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    tick_q <= tick_d;
  end

  assign data = data_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_automaton.sv
// Bench for automaton: six instances with different rules/seeds/periods checked
// every cycle against a generation-level model, plus pinned literal values.
module tb_automaton;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_e = 1'b1;

  logic [7:0]  da, db, dc, dd, de;
  logic [79:0] df;
  logic        ta, tb_t, tc, td, te, tf;

  automaton #(.WIDTH(8), .RULE(8'd126), .SEED(8'b0001_0000), .N(1)) u_a (
    .clk(clk), .rst(rst_a), .data(da), .tick(ta));
  automaton #(.WIDTH(8), .RULE(8'd126), .SEED(8'b0000_0001), .N(1)) u_b (
    .clk(clk), .rst(rst_a), .data(db), .tick(tb_t));
  automaton #(.WIDTH(8), .RULE(8'd204), .SEED(8'b1010_0101), .N(1)) u_c (
    .clk(clk), .rst(rst_a), .data(dc), .tick(tc));
  automaton #(.WIDTH(8), .RULE(8'd0), .SEED(8'b1010_0101), .N(1)) u_d (
    .clk(clk), .rst(rst_a), .data(dd), .tick(td));
  automaton #(.WIDTH(8), .RULE(8'd30), .SEED(8'b0001_0000), .N(3)) u_e (
    .clk(clk), .rst(rst_e), .data(de), .tick(te));
  automaton #(.WIDTH(80), .RULE(8'd126), .SEED(80'd1 << 40), .N(1)) u_f (
    .clk(clk), .rst(1'b0), .data(df), .tick(tf));

  localparam int NI = 6;
  int          w_c[NI]    = '{8, 8, 8, 8, 8, 80};
  int          rule_c[NI] = '{126, 126, 204, 0, 30, 126};
  int          n_c[NI]    = '{1, 1, 1, 1, 3, 1};
  logic [79:0] seed_c[NI];

  logic [79:0] m_data[NI];
  int          m_edges[NI];
  logic        m_tick[NI];

  int checks = 0;
  int errors = 0;
  int e = 0;
  int ta_cnt = 0, te_cnt0 = 0, te_cnt1 = 0;

  // One generation straight from the rule table: next[i] = RULE bit {l,s,r}.
  function automatic logic [79:0] ca_next(input logic [79:0] r, input int w, input int rule);
    logic [79:0] n;
    n = '0;
    for (int i = 0; i < w; i++) begin
      int k;
      k = 4 * int'(r[(i + 1) % w]) + 2 * int'(r[i]) + int'(r[(i + w - 1) % w]);
      n[i] = ((rule >> k) & 1) != 0;
    end
    return n;
  endfunction

  function automatic logic [79:0] act_data(input int j);
    case (j)
      0: return {72'd0, da};
      1: return {72'd0, db};
      2: return {72'd0, dc};
      3: return {72'd0, dd};
      4: return {72'd0, de};
      default: return df;
    endcase
  endfunction

  function automatic logic act_tick(input int j);
    case (j)
      0: return ta;
      1: return tb_t;
      2: return tc;
      3: return td;
      4: return te;
      default: return tf;
    endcase
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: count edges since reset; every 2N-th one produces a new generation.
  task automatic model_edge();
    for (int j = 0; j < NI; j++) begin
      logic r;
      r = (j == 4) ? rst_e : (j == 5) ? 1'b0 : rst_a;
      if (r) begin
        m_data[j]  = seed_c[j];
        m_edges[j] = 0;
        m_tick[j]  = 1'b0;
      end else begin
        m_edges[j]++;
        if (m_edges[j] % (2 * n_c[j]) == 0) begin
          m_data[j] = ca_next(m_data[j], w_c[j], rule_c[j]);
          m_tick[j] = 1'b1;
        end else begin
          m_tick[j] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int j = 0; j < NI; j++) begin
      chk($sformatf("model_data[%0d]@e%0d", j, e), act_data(j), m_data[j]);
      chk($sformatf("model_tick[%0d]@e%0d", j, e), {79'd0, act_tick(j)}, {79'd0, m_tick[j]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (!rst_a) begin
      e++;
      if (e <= 20) ta_cnt += int'(ta);
      if (e <= 23) te_cnt0 += int'(te);
      if (e >= 31 && e <= 66) te_cnt1 += int'(te);
    end
  endtask

  initial begin
    seed_c[0] = 80'h10;
    seed_c[1] = 80'h01;
    seed_c[2] = 80'hA5;
    seed_c[3] = 80'hA5;
    seed_c[4] = 80'h10;
    seed_c[5] = 80'd1 << 40;
    for (int j = 0; j < NI; j++) begin
      m_data[j]  = seed_c[j];
      m_edges[j] = 0;
      m_tick[j]  = 1'b0;
    end

    // Reset edge.
    step();
    chk("reset_data_a", {72'd0, da}, 80'h10);
    chk("reset_tick_a", {79'd0, ta}, 80'd0);
    chk("reset_data_e", {72'd0, de}, 80'h10);
    rst_a = 1'b0;
    rst_e = 1'b0;

    step();  // e=1; F has now seen 2 edges
    chk("f_first_gen", df, 80'h7 << 39);
    chk("a_no_adv_e1", {72'd0, da}, 80'h10);
    step();  // e=2
    chk("a_gen1", {72'd0, da}, 80'h38);
    chk("b_wrap_gen1", {72'd0, db}, 80'h83);
    chk("d_rule0_gen1", {72'd0, dd}, 80'h00);
    chk("a_tick_gen1", {79'd0, ta}, 80'd1);
    step();
    step();  // e=4
    chk("a_gen2", {72'd0, da}, 80'h6C);

    while (e < 23) step();
    // Assert reset in the cycle where E's counter sits at 2N-1.
    rst_e = 1'b1;
    step();  // e=24
    chk("e_rst_data", {72'd0, de}, 80'h10);
    chk("e_rst_tick", {79'd0, te}, 80'd0);
    rst_e = 1'b0;
    repeat (5) step();
    chk("e_hold_after_rst", {72'd0, de}, 80'h10);
    step();  // e=30
    chk("e_adv_after_rst", {72'd0, de}, 80'h38);
    chk("e_tick_after_rst", {79'd0, te}, 80'd1);

    while (e < 130) step();
    chk("a_tick_count", 80'(ta_cnt), 80'd10);
    chk("e_tick_count_pre", 80'(te_cnt0), 80'd3);
    chk("e_tick_count_post", 80'(te_cnt1), 80'd6);
    chk("c_identity", {72'd0, dc}, 80'hA5);
    chk("d_stays_zero", {72'd0, dd}, 80'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
